ptmch_trg_gen: RTL and testbench

PTMCH_TRG_GEN -- requirements
Module: ptmch_trg_gen

---
 rtl/ptmch_pkg.sv | 24 ++
 rtl/ptmch_trg_timer.sv | 25 ++
 rtl/ptmch_trg_gen.sv | 165 ++++++++++++++++
 tb/tb_ptmch_trg_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptmch_pkg.sv
// Shared definitions for the trigger pulse generator: FSM states, channel
// encodings and the default minimum phase length.
package ptmch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } ptmch_state_e;

  localparam logic [2:0] CMD_PROG_EXEC    = 3'd0;
  localparam logic [2:0] CMD_READ_STATUS  = 3'd1;
  localparam logic [2:0] CMD_BLOCK_ERASE  = 3'd2;
  localparam logic [2:0] CMD_PAGE_READ    = 3'd3;
  localparam logic [2:0] CMD_WRITE_STATUS = 3'd4;
  localparam logic [2:0] CMD_MAX          = CMD_WRITE_STATUS;

  localparam int PTMCH_MIN_WIDTH = 4;

  function automatic logic [7:0] clamp_min(input logic [7:0] val, input logic [7:0] floor);
    return (val < floor) ? floor : val;
  endfunction

endpackage

// File: rtl/ptmch_trg_timer.sv
// Loadable 8-bit phase down-counter; tc marks the last cycle of a phase.
module ptmch_trg_timer (
  input  logic       CLK100M,
  input  logic       RESET_N,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tc
);

  logic [7:0] count;

  // Saturates at zero so an idle timer never wraps.
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign tc = (count == 8'd0);

endmodule

// File: rtl/ptmch_trg_gen.sv
// Multi-channel trigger pulse generator: REPEAT pulses of W high / G low
// clocks on the selected channel, with abort, error and done reporting.
module ptmch_trg_gen
  import ptmch_pkg::*;
#(
  parameter int NCH       = 5,
  parameter int MIN_WIDTH = PTMCH_MIN_WIDTH
) (
  input  logic           RESET_N,
  input  logic           CLK100M,
  input  logic           START,
  input  logic           ABORT,
  input  logic [2:0]     CMD_SEL,
  input  logic [7:0]     PLS_WIDTH,
  input  logic [7:0]     PLS_GAP,
  input  logic [15:0]    REPEAT,
  output logic [NCH-1:0] TRG_PLS,
  output logic           BUSY,
  output logic           DONE,
  output logic           ERR,
  output logic [15:0]    SENT_CNT
);

  localparam logic [7:0] MIN_W8 = 8'(MIN_WIDTH);

  ptmch_state_e state, state_nx;
  logic [2:0]   sel_q, sel_nx;
  logic [7:0]   w_q, g_q, w_eff, g_eff;
  logic [15:0]  rep_q;
  logic         abort_q, abort_nx;
  logic         accept, clr_cnt, cnt_inc, done_nx, err_nx;
  logic         tmr_load, tmr_tc;
  logic [7:0]   tmr_val;
  logic         last_pulse;
  logic [NCH-1:0] trg_nx;

  assign w_eff      = clamp_min(PLS_WIDTH, MIN_W8);
  assign g_eff      = clamp_min(PLS_GAP, MIN_W8);
  assign last_pulse = ((SENT_CNT + 16'd1) == rep_q);
  assign sel_nx     = accept ? CMD_SEL : sel_q;

  ptmch_trg_timer u_timer (
    .CLK100M  (CLK100M),
    .RESET_N  (RESET_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // The final gap is one cycle shorter in GAP because its last cycle is
  // spent in IDLE presenting DONE with BUSY already low.
  always_comb begin
    state_nx = state;
    abort_nx = abort_q;
    accept   = 1'b0;
    clr_cnt  = 1'b0;
    cnt_inc  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        abort_nx = 1'b0;
        if (START) begin
          if (CMD_SEL > CMD_MAX) begin
            err_nx = 1'b1;
          end else if (REPEAT == 16'd0) begin
            done_nx = 1'b1;
            clr_cnt = 1'b1;
          end else begin
            accept   = 1'b1;
            clr_cnt  = 1'b1;
            state_nx = ST_HIGH;
            tmr_load = 1'b1;
            tmr_val  = w_eff - 8'd1;
          end
        end
      end
      ST_HIGH: begin
        if (tmr_tc) begin
          cnt_inc  = 1'b1;
          abort_nx = 1'b0;
          if (abort_q || ABORT) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_GAP;
            tmr_load = 1'b1;
            if (last_pulse) begin
              tmr_val = (g_q > 8'd1) ? g_q - 8'd2 : 8'd0;
            end else begin
              tmr_val = g_q - 8'd1;
            end
          end
        end else if (ABORT) begin
          abort_nx = 1'b1;
        end
      end
      ST_GAP: begin
        if (ABORT) begin
          state_nx = ST_IDLE;
        end else if (tmr_tc) begin
          if (SENT_CNT < rep_q) begin
            state_nx = ST_HIGH;
            tmr_load = 1'b1;
            tmr_val  = w_q - 8'd1;
          end else begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    trg_nx = '0;
    for (int i = 0; i < NCH; i++) begin
      trg_nx[i] = (state_nx == ST_HIGH) && (sel_nx == 3'(i));
    end
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      abort_q  <= 1'b0;
      sel_q    <= '0;
      w_q      <= '0;
      g_q      <= '0;
      rep_q    <= '0;
      SENT_CNT <= '0;
    end else begin
      state   <= state_nx;
      abort_q <= abort_nx;
      if (accept) begin
        sel_q <= CMD_SEL;
        w_q   <= w_eff;
        g_q   <= g_eff;
        rep_q <= REPEAT;
      end
      if (clr_cnt) begin
        SENT_CNT <= '0;
      end else if (cnt_inc) begin
        SENT_CNT <= SENT_CNT + 16'd1;
      end
    end
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      TRG_PLS <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      TRG_PLS <= trg_nx;
      BUSY    <= (state_nx != ST_IDLE);
      DONE    <= done_nx;
      ERR     <= err_nx;
    end
  end

endmodule

// File: tb/tb_ptmch_trg_gen.sv
// Scoreboard bench for ptmch_trg_gen: a run-level model predicts output events,
// a negedge monitor detects them on the DUT and compares in order.
module tb_ptmch_trg_gen;

  localparam int NCH = 5;

  logic           CLK100M = 1'b0;
  logic           RESET_N = 1'b0;
  logic           START   = 1'b0;
  logic           ABORT   = 1'b0;
  logic [2:0]     CMD_SEL   = '0;
  logic [7:0]     PLS_WIDTH = '0;
  logic [7:0]     PLS_GAP   = '0;
  logic [15:0]    REPEAT    = '0;
  logic [NCH-1:0] TRG_PLS;
  logic           BUSY, DONE, ERR;
  logic [15:0]    SENT_CNT;

  ptmch_trg_gen #(.NCH(NCH), .MIN_WIDTH(4)) dut (
    .RESET_N   (RESET_N),
    .CLK100M   (CLK100M),
    .START     (START),
    .ABORT     (ABORT),
    .CMD_SEL   (CMD_SEL),
    .PLS_WIDTH (PLS_WIDTH),
    .PLS_GAP   (PLS_GAP),
    .REPEAT    (REPEAT),
    .TRG_PLS   (TRG_PLS),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .SENT_CNT  (SENT_CNT)
  );

  always #5 CLK100M = ~CLK100M;

  typedef enum logic [2:0] {EV_PULSE, EV_BUSY_RISE, EV_BUSY_FALL, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [31:0] cyc;
    logic [2:0]  chan;
    logic [15:0] width;
    logic [15:0] sent;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int unsigned last_sent = 0;

  always @(posedge CLK100M) cyc <= cyc + 1;

  function automatic ev_t mkEv(input ev_kind_e k, input int unsigned c, input int unsigned ch,
                               input int unsigned wd, input int unsigned st);
    ev_t e;
    e.kind  = k;
    e.cyc   = c;
    e.chan  = 3'(ch);
    e.width = 16'(wd);
    e.sent  = 16'(st);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic scoreEvent(input ev_t got);
    ev_t want;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL unexpected_event: got kind=%0d cyc=%0d ch=%0d width=%0d sent=%0d, expected none",
               got.kind, got.cyc, got.chan, got.width, got.sent);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL event: got kind=%0d cyc=%0d ch=%0d width=%0d sent=%0d, expected kind=%0d cyc=%0d ch=%0d width=%0d sent=%0d",
                 got.kind, got.cyc, got.chan, got.width, got.sent,
                 want.kind, want.cyc, want.chan, want.width, want.sent);
      end
    end
  endtask

  // Monitor: pulse ends, BUSY edges, DONE and ERR strobes, in a fixed per-cycle order.
  logic [NCH-1:0] prev_trg  = '0;
  logic           prev_busy = 1'b0;
  int unsigned    rise_cyc [NCH];

  always @(negedge CLK100M) begin
    if (!RESET_N) begin
      prev_trg  = '0;
      prev_busy = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (TRG_PLS[i] && !prev_trg[i]) rise_cyc[i] = cyc;
        if (!TRG_PLS[i] && prev_trg[i])
          scoreEvent(mkEv(EV_PULSE, rise_cyc[i], i, cyc - rise_cyc[i], SENT_CNT));
      end
      if (BUSY && !prev_busy) scoreEvent(mkEv(EV_BUSY_RISE, cyc, 0, 0, SENT_CNT));
      if (!BUSY && prev_busy) scoreEvent(mkEv(EV_BUSY_FALL, cyc, 0, 0, SENT_CNT));
      if (DONE) scoreEvent(mkEv(EV_DONE, cyc, 0, 0, SENT_CNT));
      if (ERR)  scoreEvent(mkEv(EV_ERR, cyc, 0, 0, SENT_CNT));
      prev_trg  = TRG_PLS;
      prev_busy = BUSY;
    end
  end

  // Downstream trigger counter with a two-sample stability filter per channel.
  logic [NCH-1:0] samp1 = '0, samp2 = '0, filt = '0;
  int             trg_count [NCH];
  bit             cnt_clr = 1'b0;

  always @(posedge CLK100M) begin
    samp1 <= TRG_PLS;
    samp2 <= samp1;
    for (int i = 0; i < NCH; i++) begin
      if (samp1[i] && samp2[i]) filt[i] <= 1'b1;
      else if (!samp1[i] && !samp2[i]) filt[i] <= 1'b0;
      if (cnt_clr) trg_count[i] <= 0;
      else if (samp1[i] && samp2[i] && !filt[i]) trg_count[i] <= trg_count[i] + 1;
    end
  end

  // One run: predict its events from the pulse-train rules, then drive it to completion
  // while scrambling the configuration inputs. ab_off < 0 means no abort.
  task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] pw, input logic [7:0] pg,
                               input logic [15:0] rep, input int ab_off, input int mid_off);
    int unsigned s, w, g, p, end_c, n_pulses, k, pos;
    bit aborted;
    @(posedge CLK100M); #1;
    s = cyc;
    START = 1'b1; CMD_SEL = sel; PLS_WIDTH = pw; PLS_GAP = pg; REPEAT = rep;
    ABORT = (ab_off == 0);
    w = (pw < 4) ? 4 : pw;
    g = (pg < 4) ? 4 : pg;
    p = w + g;
    if (sel > 3'd4) begin
      exp_q.push_back(mkEv(EV_ERR, s + 1, 0, 0, last_sent));
      end_c = s + 1;
    end else if (rep == 16'd0) begin
      exp_q.push_back(mkEv(EV_DONE, s + 1, 0, 0, 0));
      last_sent = 0;
      end_c = s + 1;
    end else begin
      n_pulses = rep;
      end_c    = s + rep * p;
      aborted  = 1'b0;
      if (ab_off >= 1 && ab_off <= int'(rep * p) - 1) begin
        k        = (ab_off - 1) / p;
        pos      = (ab_off - 1) % p;
        n_pulses = k + 1;
        aborted  = 1'b1;
        end_c    = (pos < w) ? s + 1 + k * p + w : s + ab_off + 1;
      end
      exp_q.push_back(mkEv(EV_BUSY_RISE, s + 1, 0, 0, 0));
      for (int unsigned j = 0; j < n_pulses; j++)
        exp_q.push_back(mkEv(EV_PULSE, s + 1 + j * p, sel, w, j + 1));
      exp_q.push_back(mkEv(EV_BUSY_FALL, end_c, 0, 0, n_pulses));
      if (!aborted) exp_q.push_back(mkEv(EV_DONE, end_c, 0, 0, rep));
      last_sent = n_pulses;
    end
    while (cyc <= end_c) begin
      @(posedge CLK100M); #1;
      START     = (mid_off > 0 && cyc == s + mid_off);
      ABORT     = (ab_off > 0 && cyc == s + ab_off);
      CMD_SEL   = 3'($urandom_range(0, 7));
      PLS_WIDTH = 8'($urandom);
      PLS_GAP   = 8'($urandom);
      REPEAT    = 16'($urandom);
    end
    START = 1'b0;
    ABORT = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int unsigned s;
    logic [2:0]  rsel;
    repeat (3) @(posedge CLK100M);
    #1;
    checkOutput("reset_trg",  32'(TRG_PLS), 0);
    checkOutput("reset_busy", 32'(BUSY), 0);
    checkOutput("reset_done", 32'(DONE), 0);
    checkOutput("reset_err",  32'(ERR), 0);
    checkOutput("reset_sent", 32'(SENT_CNT), 0);
    RESET_N = 1'b1;

    applyStimulus(3'd3, 8'd10, 8'd6, 16'd3, -1, 2);
    checkOutput("sent_after_three", 32'(SENT_CNT), 3);
    applyStimulus(3'd0, 8'd1, 8'd0, 16'd2, -1, 2);
    applyStimulus(3'd6, 8'd8, 8'd8, 16'd2, -1, 0);
    checkOutput("err_trg_idle", 32'(TRG_PLS), 0);
    applyStimulus(3'd1, 8'd5, 8'd5, 16'd0, -1, 0);
    applyStimulus(3'd2, 8'd8, 8'd8, 16'd5, 19, 5);
    checkOutput("sent_after_abort", 32'(SENT_CNT), 2);
    checkOutput("busy_after_abort", 32'(BUSY), 0);

    // Reset in the middle of the second high phase.
    @(posedge CLK100M); #1;
    s = cyc;
    START = 1'b1; CMD_SEL = 3'd2; PLS_WIDTH = 8'd6; PLS_GAP = 8'd4; REPEAT = 16'd3;
    exp_q.push_back(mkEv(EV_BUSY_RISE, s + 1, 0, 0, 0));
    exp_q.push_back(mkEv(EV_PULSE, s + 1, 2, 6, 1));
    @(posedge CLK100M); #1;
    START = 1'b0;
    while (cyc < s + 13) begin
      @(posedge CLK100M); #1;
    end
    checkOutput("pre_reset_trg",  32'(TRG_PLS), 4);
    checkOutput("pre_reset_sent", 32'(SENT_CNT), 1);
    RESET_N = 1'b0;
    #1;
    checkOutput("async_reset_trg",  32'(TRG_PLS), 0);
    checkOutput("async_reset_busy", 32'(BUSY), 0);
    checkOutput("async_reset_sent", 32'(SENT_CNT), 0);
    exp_q.delete();
    last_sent = 0;
    repeat (2) @(posedge CLK100M);
    #1;
    RESET_N = 1'b1;
    repeat (20) @(posedge CLK100M);
    #1;
    checkOutput("post_reset_trg",  32'(TRG_PLS), 0);
    checkOutput("post_reset_busy", 32'(BUSY), 0);

    // Loopback: 20 pulses on each channel into the filtered trigger counter.
    cnt_clr = 1'b1;
    repeat (2) @(posedge CLK100M);
    #1;
    cnt_clr = 1'b0;
    for (int ch = 0; ch < NCH; ch++)
      applyStimulus(3'(ch), 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)), 16'd20, -1, 2);
    repeat (4) @(posedge CLK100M);
    #1;
    for (int ch = 0; ch < NCH; ch++)
      checkOutput($sformatf("loop_count_ch%0d", ch), 32'(trg_count[ch]), 20);

    for (int r = 0; r < 40; r++) begin
      rsel = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      begin
        logic [15:0] rrep;
        int          rab;
        rrep = 16'($urandom_range(0, 4));
        rab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 80)) : -1;
        applyStimulus(rsel, 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), rrep, rab,
                      (rsel <= 3'd4 && rrep != 16'd0) ? 2 : 0);
      end
    end

    repeat (5) @(posedge CLK100M);
    #1;
    checkOutput("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
